// File: rtl/bias_relu_stage_pkg.sv
// Shared widths, lane types and the rescale/saturate/ReLU helper for the
// layer-0 bias + activation stage.
package nn_pkg;

    localparam int LANES      = 16;
    localparam int ACC_W      = 32;
    localparam int BIAS_W     = 16;
    localparam int OUT_W      = 16;
    localparam int WORD_LANES = 8;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [BIAS_W-1:0] bias_t;
    typedef logic signed [OUT_W-1:0]  act_t;
    typedef logic signed [ACC_W:0]    sum_t;

    localparam sum_t SAT_HI = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam sum_t SAT_LO = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Arithmetic shift floors toward -inf, then clamp into the activation range.
    function automatic act_t sat_relu(input sum_t s, input int unsigned shift, input logic relu);
        sum_t r;
        act_t res;
        r = s >>> shift;
        if (relu && r[ACC_W]) begin
            res = '0;
        end else if (r > SAT_HI) begin
            res = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (r < SAT_LO) begin
            res = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            res = r[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bias_relu_stage_if.sv
// Valid/ready stream bundles: accumulator beats in, activation beats out.
interface bias_relu_in_if;
    import nn_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [LANES*ACC_W-1:0] acc;
    logic                   last;

    modport master (output valid, acc, last, input ready);
    modport slave  (input valid, acc, last, output ready);
endinterface

interface bias_relu_out_if;
    import nn_pkg::*;

    logic                   valid;
    logic                   ready;
    logic [LANES*OUT_W-1:0] data;
    logic [LANES-1:0]       mask;
    logic                   last;

    modport master (output valid, data, mask, last, input ready);
    modport slave  (input valid, data, mask, last, output ready);
endinterface

// File: rtl/bias_relu_stage_lane.sv
// One lane of the stage: align the bias, add, rescale, saturate, optional ReLU.
module bias_lane_alu
    import nn_pkg::*;
#(
    parameter int BIAS_SHIFT = 8,
    parameter int OUT_SHIFT  = 8,
    parameter int RELU       = 1
) (
    input  acc_t  acc_i,
    input  bias_t bias_i,
    output act_t  act_o
);
    sum_t bias_ext_s;
    sum_t bias_sh_s;
    sum_t acc_ext_s;
    sum_t sum_s;

    // One guard bit above ACC_W keeps the add free of overflow.
    assign bias_ext_s = {{(ACC_W + 1 - BIAS_W){bias_i[BIAS_W-1]}}, bias_i};
    assign bias_sh_s  = bias_ext_s <<< BIAS_SHIFT;
    assign acc_ext_s  = {acc_i[ACC_W-1], acc_i};
    assign sum_s      = acc_ext_s + bias_sh_s;
    assign act_o      = sat_relu(sum_s, OUT_SHIFT, RELU != 0);

endmodule

// File: rtl/bias_relu_stage.sv
// Two-stage bias + activation pipeline between the MAC array and the next
// layer; fetches two packed bias ROM words per 16-lane beat.
module bias_relu_stage
    import nn_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_NEURONS = 122,
    parameter int BIAS_SHIFT  = 8,
    parameter int OUT_SHIFT   = 8,
    parameter int RELU        = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bias_relu_in_if.slave                in_s,
    output logic [ADDR_WIDTH-1:0]        mem_addr_a,
    output logic [ADDR_WIDTH-1:0]        mem_addr_b,
    input  logic [WORD_LANES*BIAS_W-1:0] mem_q_a,
    input  logic [WORD_LANES*BIAS_W-1:0] mem_q_b,
    bias_relu_out_if.master              out_m,
    output logic                         frame_err
);
    localparam int BEATS  = (NUM_NEURONS + LANES - 1) / LANES;
    localparam int BEAT_W = ADDR_WIDTH - 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0]      beat_q, beat_d, s1_beat_q, s1_beat_d, addr_beat_s;
    logic                   s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d, frame_err_q, frame_err_d;
    logic [LANES*ACC_W-1:0] s1_acc_q, s1_acc_d;
    logic [LANES*OUT_W-1:0] out_data_q, out_data_d, lane_data_s;
    logic [LANES-1:0]       out_mask_q, out_mask_d, lane_mask_s;
    logic                   s2_en_s, s1_adv_s, in_ready_s, in_hs_s, at_end_s;
    act_t                   lane_act_s [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bias_t bias_s;
        if (i < WORD_LANES) begin : g_port_a
            assign bias_s = mem_q_a[(WORD_LANES-1-i)*BIAS_W +: BIAS_W];
        end else begin : g_port_b
            assign bias_s = mem_q_b[(2*WORD_LANES-1-i)*BIAS_W +: BIAS_W];
        end
        bias_lane_alu #(
            .BIAS_SHIFT (BIAS_SHIFT),
            .OUT_SHIFT  (OUT_SHIFT),
            .RELU       (RELU)
        ) u_alu (
            .acc_i  (s1_acc_q[(LANES-1-i)*ACC_W +: ACC_W]),
            .bias_i (bias_s),
            .act_o  (lane_act_s[i])
        );
    end

    // Pack lane results; lanes beyond the last real neuron read as zero.
    always_comb begin
        lane_data_s = '0;
        lane_mask_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((int'(s1_beat_q) * LANES + i) < NUM_NEURONS) begin
                lane_data_s[(LANES-1-i)*OUT_W +: OUT_W] = lane_act_s[i];
                lane_mask_s[LANES-1-i]                  = 1'b1;
            end else begin
                lane_data_s[(LANES-1-i)*OUT_W +: OUT_W] = '0;
                lane_mask_s[LANES-1-i]                  = 1'b0;
            end
        end
    end

    // Handshakes, frame counter, ROM address mux and next-state for both stages.
    always_comb begin
        s2_en_s    = !out_valid_q || out_m.ready;
        s1_adv_s   = s1_valid_q && s2_en_s;
        in_ready_s = !s1_valid_q || s2_en_s;
        in_hs_s    = in_s.valid && in_ready_s;
        at_end_s   = (beat_q == LAST_BEAT);

        beat_d      = beat_q;
        frame_err_d = 1'b0;
        if (in_hs_s) begin
            frame_err_d = (in_s.last != at_end_s);
            if (in_s.last || at_end_s) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end else begin
            beat_d = beat_q;
        end

        // A stalled stage 1 keeps re-reading its own words so mem_q_* stays valid.
        if (s1_valid_q && !s1_adv_s) begin
            addr_beat_s = s1_beat_q;
        end else begin
            addr_beat_s = beat_q;
        end

        if (in_ready_s) begin
            s1_valid_d = in_s.valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (in_hs_s) begin
            s1_acc_d  = in_s.acc;
            s1_beat_d = beat_q;
        end else begin
            s1_acc_d  = s1_acc_q;
            s1_beat_d = s1_beat_q;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        out_last_d  = out_last_q;
        if (s2_en_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = lane_data_s;
                out_mask_d = lane_mask_s;
                out_last_d = (s1_beat_q == LAST_BEAT);
            end else begin
                out_data_d = out_data_q;
                out_mask_d = out_mask_q;
                out_last_d = out_last_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline, frame counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= '0;
            s1_beat_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            s1_valid_q  <= s1_valid_d;
            s1_acc_q    <= s1_acc_d;
            s1_beat_q   <= s1_beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_s.ready  = in_ready_s;
    assign mem_addr_a  = {addr_beat_s, 1'b0};
    assign mem_addr_b  = {addr_beat_s, 1'b1};
    assign out_m.valid = out_valid_q;
    assign out_m.data  = out_data_q;
    assign out_m.mask  = out_mask_q;
    assign out_m.last  = out_last_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_bias_relu_stage.sv
// Scoreboard bench: one ReLU and one linear instance share the same stimulus
// and bias ROM image; expected beats are queued at accept and compared at output.
module tb_bias_relu_stage;
    import nn_pkg::*;

    typedef struct {
        logic [255:0] d1;
        logic [255:0] d0;
        logic [15:0]  mask;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   addr_a1, addr_b1, addr_a0, addr_b0;
    logic [127:0] q_a1, q_b1, q_a0, q_b0;
    logic         ferr1, ferr0;
    logic [127:0] rom [16];
    exp_t         exp_q [$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           tb_beat  = 0;
    logic         ferr_exp = 1'b0;

    bias_relu_in_if  in1 ();
    bias_relu_in_if  in0 ();
    bias_relu_out_if out1 ();
    bias_relu_out_if out0 ();

    assign in0.valid  = in1.valid;
    assign in0.acc    = in1.acc;
    assign in0.last   = in1.last;
    assign out0.ready = out1.ready;

    bias_relu_stage #(.RELU(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_s(in1),
        .mem_addr_a(addr_a1), .mem_addr_b(addr_b1), .mem_q_a(q_a1), .mem_q_b(q_b1),
        .out_m(out1), .frame_err(ferr1)
    );

    bias_relu_stage #(.RELU(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_s(in0),
        .mem_addr_a(addr_a0), .mem_addr_b(addr_b0), .mem_q_a(q_a0), .mem_q_b(q_b0),
        .out_m(out0), .frame_err(ferr0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered bias ROMs, one per instance, identical contents.
    always @(posedge clk) begin
        q_a1 <= rom[addr_a1];
        q_b1 <= rom[addr_b1];
        q_a0 <= rom[addr_a0];
        q_b0 <= rom[addr_b0];
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] gen_acc();
        logic [511:0] v;
        logic [31:0]  x;
        for (int l = 0; l < 16; l++) begin
            x = $urandom() >> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) x = -x;
            v[(15-l)*32 +: 32] = x;
        end
        return v;
    endfunction

    function automatic exp_t model(input logic [511:0] acc, input int k);
        exp_t         e;
        longint       a, b, s, r, r0;
        logic [127:0] w;
        e.d1   = '0;
        e.d0   = '0;
        e.mask = '0;
        e.last = (k == 7);
        for (int l = 0; l < 16; l++) begin
            if (16 * k + l < 122) begin
                w = rom[2 * k + l / 8];
                a = longint'($signed(acc[(15-l)*32 +: 32]));
                b = longint'($signed(w[(7 - l % 8)*16 +: 16]));
                s = a + b * 256;
                r = s >>> 8;
                if (r > 32767) r = 32767;
                else if (r < -32768) r = -32768;
                r0 = r;
                if (r < 0) r = 0;
                e.d1[(15-l)*16 +: 16] = r[15:0];
                e.d0[(15-l)*16 +: 16] = r0[15:0];
                e.mask[15-l] = 1'b1;
            end
        end
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                tb_beat  = 0;
                ferr_exp = 1'b0;
            end else begin
                check_eq("frame_err_relu1", ferr1, ferr_exp);
                check_eq("frame_err_relu0", ferr0, ferr_exp);
                if (out1.valid && out1.ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("data_relu1", out1.data, e.d1);
                        check_eq("data_relu0", out0.data, e.d0);
                        check_eq("mask", out1.mask, e.mask);
                        check_eq("last", out1.last, e.last);
                        check_eq("valid_relu0", out0.valid, 1'b1);
                    end
                end
                ferr_exp = 1'b0;
                if (in1.valid && in1.ready) begin
                    exp_q.push_back(model(in1.acc, tb_beat));
                    ferr_exp = (in1.last != (tb_beat == 7));
                    tb_beat  = (in1.last || tb_beat == 7) ? 0 : tb_beat + 1;
                end
            end
        end
    end

    task automatic send_beat(input logic [511:0] acc, input logic last);
        int n    = 0;
        bit done = 1'b0;
        in1.valid = 1'b1;
        in1.acc   = acc;
        in1.last  = last;
        while (!done && n < 50) begin
            @(negedge clk);
            done = in1.ready;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("hs_timeout", done, 1'b1);
        in1.valid = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [511:0] acc;
        logic [255:0] snap;
        longint       t0;
        in1.valid  = 1'b0;
        in1.acc    = '0;
        in1.last   = 1'b0;
        out1.ready = 1'b1;
        rst_n      = 1'b0;
        for (int w = 0; w < 16; w++) rom[w] = {$urandom(), $urandom(), $urandom(), $urandom()};
        rom[0][127:64] = {16'h0100, 16'h7FFF, 16'h8000, 16'h0000};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_out_valid", out1.valid, 1'b0);
        check_eq("rst_out_data", out1.data, '0);
        check_eq("rst_out_mask", out1.mask, '0);
        check_eq("rst_out_last", out1.last, 1'b0);
        check_eq("rst_in_ready", in1.ready, 1'b1);

        // Directed first beat: latency and the saturation/ReLU corner values.
        @(posedge clk);
        #1;
        acc = gen_acc();
        acc[511:384] = {32'h00010000, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFC18};
        in1.acc   = acc;
        in1.last  = 1'b0;
        in1.valid = 1'b1;
        @(negedge clk);
        check_eq("accept_ready", in1.ready, 1'b1);
        check_eq("accept_addr_a", addr_a1, 4'd0);
        check_eq("accept_addr_b", addr_b1, 4'd1);
        @(posedge clk);
        #1 in1.valid = 1'b0;
        @(negedge clk);
        check_eq("lat_cycle1_valid", out1.valid, 1'b0);
        @(negedge clk);
        check_eq("lat_cycle2_valid", out1.valid, 1'b1);
        check_eq("lane0_basic", out1.data[255:240], 16'h0200);
        check_eq("lane1_sat_hi", out1.data[239:224], 16'h7FFF);
        check_eq("lane2_sat_lo_relu", out1.data[223:208], 16'h0000);
        check_eq("lane2_sat_lo_lin", out0.data[223:208], 16'h8000);
        check_eq("lane3_neg_relu", out1.data[207:192], 16'h0000);
        check_eq("lane3_neg_lin", out0.data[207:192], 16'hFFFC);

        // Rest of the frame, then a full back-to-back frame at one beat per cycle.
        @(posedge clk);
        #1;
        for (int k = 1; k < 8; k++) send_beat(gen_acc(), k == 7);
        drain(3);
        t0 = $time;
        for (int k = 0; k < 8; k++) send_beat(gen_acc(), k == 7);
        check_eq("throughput_cycles", ($time - t0) / 10, 8);
        drain(3);

        // Backpressure with three beats offered.
        out1.ready = 1'b0;
        fork
            begin
                send_beat(gen_acc(), 1'b0);
                send_beat(gen_acc(), 1'b0);
                send_beat(gen_acc(), 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                snap = out1.data;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", in1.ready, 1'b0);
                    check_eq("bp_addr_a", addr_a1, 4'd2);
                    check_eq("bp_addr_b", addr_b1, 4'd3);
                    check_eq("bp_hold_valid", out1.valid, 1'b1);
                    check_eq("bp_hold_data", out1.data, snap);
                end
                @(posedge clk);
                #1 out1.ready = 1'b1;
            end
        join
        drain(4);

        // Early in_last on beat 3, then a frame whose beat 7 lacks in_last.
        send_beat(gen_acc(), 1'b1);
        drain(3);
        @(negedge clk);
        check_eq("ferr_next_addr_a", addr_a1, 4'd0);
        check_eq("ferr_next_addr_b", addr_b1, 4'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) send_beat(gen_acc(), 1'b0);
        drain(4);

        // Asynchronous reset with beats in flight.
        out1.ready = 1'b0;
        send_beat(gen_acc(), 1'b0);
        send_beat(gen_acc(), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out1.valid, 1'b0);
        check_eq("arst_out_data", out1.data, '0);
        check_eq("arst_out_valid_lin", out0.valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        out1.ready = 1'b1;
        @(negedge clk);
        check_eq("post_rst_addr_a", addr_a1, 4'd0);
        check_eq("post_rst_addr_b", addr_b1, 4'd1);
        @(posedge clk);
        #1;
        send_beat(gen_acc(), 1'b0);
        drain(5);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
